// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the dual-core memory arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W-1:0]     wdata;
    logic [DEF_DATA_W/8-1:0]   wstrb;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin arbiter with one-hot grant
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_id,
  output logic [1:0] grant
);

  // Remembers the most recently served core; reset to 1 so core0 wins the first tie
  logic last_grant;

  // Record the served core when the transaction completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= update_id;
    end
  end

  // Sole requester wins; on a tie the core that was not served last wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// rtl/dual_core_mem_arbiter.sv - merges two core data-memory ports onto one shared memory port
module dual_core_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                c0_req_valid,
  output logic                c0_req_ready,
  input  logic                c0_req_we,
  input  logic [ADDR_W-1:0]   c0_req_addr,
  input  logic [DATA_W-1:0]   c0_req_wdata,
  input  logic [DATA_W/8-1:0] c0_req_wstrb,
  output logic                c0_rsp_valid,
  output logic [DATA_W-1:0]   c0_rsp_rdata,
  output logic                c0_rsp_err,
  input  logic                c1_req_valid,
  output logic                c1_req_ready,
  input  logic                c1_req_we,
  input  logic [ADDR_W-1:0]   c1_req_addr,
  input  logic [DATA_W-1:0]   c1_req_wdata,
  input  logic [DATA_W/8-1:0] c1_req_wstrb,
  output logic                c1_rsp_valid,
  output logic [DATA_W-1:0]   c1_rsp_rdata,
  output logic                c1_rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_t              state_q, state_d;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [CNT_W-1:0]    tmo_cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [1:0]          grant;
  logic                accept;
  logic                in_flight;
  logic                tmo_fire;
  logic                rsp0;
  logic                rsp1;

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({c1_req_valid, c0_req_valid}),
    .update    (state_q == RESP),
    .update_id (owner_q),
    .grant     (grant)
  );

  assign accept    = (state_q == IDLE) && (grant != 2'b00);
  assign in_flight = (state_q == ISSUE) || (state_q == WAIT);
  // The last allowed cycle is the one where the counter reads TIMEOUT_CYCLES-1;
  // a transaction that completes normally in that cycle still wins.
  assign tmo_fire  = (tmo_cnt_q >= TMO_LAST) &&
                     (((state_q == ISSUE) && !mem_ready) ||
                      ((state_q == WAIT) && !mem_rvalid));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rvalid is only looked at in WAIT, so data coinciding with accept or arriving late is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        if (mem_ready)     state_d = we_q ? RESP : WAIT;
        else if (tmo_fire) state_d = RESP;
      end
      WAIT:  if (mem_rvalid || tmo_fire) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready only in IDLE for the granted core, response muxed to the owner only
  always_comb begin
    c0_req_ready = rst_n && (state_q == IDLE) && grant[0];
    c1_req_ready = rst_n && (state_q == IDLE) && grant[1];
    mem_valid    = (state_q == ISSUE);
    rsp0         = (state_q == RESP) && !owner_q;
    rsp1         = (state_q == RESP) && owner_q;
    c0_rsp_valid = rsp0;
    c1_rsp_valid = rsp1;
    c0_rsp_rdata = rsp0 ? rdata_q : '0;
    c1_rsp_rdata = rsp1 ? rdata_q : '0;
    c0_rsp_err   = rsp0 && err_q;
    c1_rsp_err   = rsp1 && err_q;
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  // Request latch: captured from the granted core on accept, held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      owner_q <= grant[1];
      we_q    <= grant[1] ? c1_req_we    : c0_req_we;
      addr_q  <= grant[1] ? c1_req_addr  : c0_req_addr;
      wdata_q <= grant[1] ? c1_req_wdata : c0_req_wdata;
      wstrb_q <= grant[1] ? c1_req_wstrb : c0_req_wstrb;
    end
  end

  // Watchdog: cleared when entering ISSUE, counts ISSUE/WAIT cycles, saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if (in_flight && (tmo_cnt_q != TMO_MAX)) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Response payload: zeroed on accept, read data captured in WAIT, error flagged on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if ((state_q == WAIT) && mem_rvalid) begin
      rdata_q <= mem_rdata;
    end else if (tmo_fire) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb/tb_dual_core_mem_arbiter.sv - scoreboard bench for dual_core_mem_arbiter
module tb_dual_core_mem_arbiter;

  localparam int TMO = 8;

  typedef struct {
    int          core;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        c0_req_valid, c0_req_ready, c0_req_we;
  logic [31:0] c0_req_addr, c0_req_wdata;
  logic [3:0]  c0_req_wstrb;
  logic        c0_rsp_valid, c0_rsp_err;
  logic [31:0] c0_rsp_rdata;
  logic        c1_req_valid, c1_req_ready, c1_req_we;
  logic [31:0] c1_req_addr, c1_req_wdata;
  logic [3:0]  c1_req_wstrb;
  logic        c1_rsp_valid, c1_rsp_err;
  logic [31:0] c1_rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          stall = 0;
  int          late_rvalid = 0;
  bit          rd_en = 1;
  bit          rv_pend = 0;
  logic [31:0] rv_data = '0;
  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        e0, e1, e2, e3;
  int          gc;
  bit          seen;

  dual_core_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_we(c0_req_we),
    .c0_req_addr(c0_req_addr), .c0_req_wdata(c0_req_wdata), .c0_req_wstrb(c0_req_wstrb),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_rdata(c0_rsp_rdata), .c0_rsp_err(c0_rsp_err),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_we(c1_req_we),
    .c1_req_addr(c1_req_addr), .c1_req_wdata(c1_req_wdata), .c1_req_wstrb(c1_req_wstrb),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_rdata(c1_rsp_rdata), .c1_rsp_err(c1_rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int core, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic [31:0] rdata, input bit err, input int lat);
    exp_t e;
    e.core = core; e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
    e.rdata = rdata; e.err = err; e.lat = lat;
    return e;
  endfunction

  task automatic drive(input exp_t e);
    if (e.core == 0) begin
      c0_req_we = e.we; c0_req_addr = e.addr; c0_req_wdata = e.wdata; c0_req_wstrb = e.wstrb;
      c0_req_valid = 1'b1;
    end else begin
      c1_req_we = e.we; c1_req_addr = e.addr; c1_req_wdata = e.wdata; c1_req_wstrb = e.wstrb;
      c1_req_valid = 1'b1;
    end
  endtask

  task automatic stop_req(input int core);
    if (core == 0) c0_req_valid = 1'b0;
    else           c1_req_valid = 1'b0;
  endtask

  task automatic wait_accept(output int core);
    bit got;
    got  = 1'b0;
    core = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (c0_req_valid && c0_req_ready) begin core = 0; got = 1'b1; end
      else if (c1_req_valid && c1_req_ready) begin core = 1; got = 1'b1; end
    end
    check("accept_seen", got, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Memory model plus scoreboard monitor, all sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      rv_pend    = 1'b0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (rv_pend) begin
        mem_rvalid = 1'b1; mem_rdata = rv_data; rv_pend = 1'b0;
      end else if (late_rvalid > 0) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; late_rvalid--;
      end
      mem_ready = 1'b0;
      if (mem_valid) begin
        if (sb.size() == 0) begin
          check("mem_valid_unexpected", 1, 0);
        end else begin
          check("mem_we", mem_we, sb[0].we);
          check("mem_addr", mem_addr, sb[0].addr);
          check("mem_wdata", mem_wdata, sb[0].wdata);
          check("mem_wstrb", mem_wstrb, sb[0].wstrb);
        end
        if (stall > 0) begin
          stall--;
        end else begin
          mem_ready = 1'b1;
          if (!mem_we && rd_en && sb.size() != 0) begin
            rv_pend = 1'b1; rv_data = sb[0].rdata;
          end
        end
      end
      if (c0_req_ready && c1_req_ready) check("both_ready", 1, 0);
      if ((c0_req_valid && c0_req_ready) || (c1_req_valid && c1_req_ready)) begin
        if (sb.size() == 0) check("accept_unexpected", 1, 0);
        else                check("accept_core", (c1_req_valid && c1_req_ready), sb[0].core);
        acc_cyc = cyc;
      end
      if (c0_rsp_valid || c1_rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_both", c0_rsp_valid && c1_rsp_valid, 0);
          check("rsp_core", c1_rsp_valid, mon_e.core);
          check("rsp_rdata", mon_e.core ? c1_rsp_rdata : c0_rsp_rdata, mon_e.rdata);
          check("rsp_err", mon_e.core ? c1_rsp_err : c0_rsp_err, mon_e.err);
          check("rsp_other_zero", mon_e.core ? {c0_rsp_rdata, c0_rsp_err} : {c1_rsp_rdata, c1_rsp_err}, 0);
          check("rsp_latency", cyc - acc_cyc, mon_e.lat);
        end
      end else begin
        check("rsp_idle_zero", |{c0_rsp_rdata, c1_rsp_rdata, c0_rsp_err, c1_rsp_err}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    c0_req_valid = 0; c0_req_we = 0; c0_req_addr = 0; c0_req_wdata = 0; c0_req_wstrb = 0;
    c1_req_valid = 0; c1_req_we = 0; c1_req_addr = 0; c1_req_wdata = 0; c1_req_wstrb = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ready", {c0_req_ready, c1_req_ready}, 0);
    check("rst_rsp", {c0_rsp_valid, c1_rsp_valid, c0_rsp_err, c1_rsp_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read from core0
    sb.push_back(mk(0, 0, 32'h100, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 3));
    drive(sb[0]);
    wait_accept(gc);
    check("t2_grant", gc, 0);
    @(posedge clk); #1;
    stop_req(0);
    drain();

    // Reset in the middle of ISSUE, then a fresh request after release
    stall = 10;
    sb.push_back(mk(1, 1, 32'h200, 32'h1234_5678, 4'hF, 32'h0, 0, 2));
    drive(sb[0]);
    wait_accept(gc);
    @(posedge clk); #1;
    stop_req(1);
    @(posedge clk); #1;
    check("t1_issue_before_rst", mem_valid, 1);
    c0_req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t1_rst_mem_valid", mem_valid, 0);
    check("t1_rst_ready", {c0_req_ready, c1_req_ready}, 0);
    check("t1_rst_rsp", {c0_rsp_valid, c1_rsp_valid}, 0);
    check("t1_rst_mem_addr", mem_addr, 0);
    c0_req_valid = 1'b0;
    stall = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sb.push_back(mk(1, 1, 32'h204, 32'h0F0F_0F0F, 4'hF, 32'h0, 0, 2));
    drive(sb[0]);
    rst_n = 1'b1;
    #1;
    check("t1_ready_after_rst", c1_req_ready, 1);
    wait_accept(gc);
    @(posedge clk); #1;
    stop_req(1);
    drain();

    // Both cores requesting writes continuously: grants alternate
    e0 = mk(0, 1, 32'h10, 32'hA0A0_0001, 4'hF, 0, 0, 2);
    e1 = mk(1, 1, 32'h14, 32'hB1B1_0001, 4'hC, 0, 0, 2);
    e2 = mk(0, 1, 32'h18, 32'hA0A0_0002, 4'h1, 0, 0, 2);
    e3 = mk(1, 1, 32'h1F, 32'hB1B1_0002, 4'h8, 0, 0, 2);
    sb.push_back(e0); sb.push_back(e1); sb.push_back(e2); sb.push_back(e3);
    drive(e0); drive(e1);
    wait_accept(gc); check("t3_grant0", gc, 0); @(posedge clk); #1; drive(e2);
    wait_accept(gc); check("t3_grant1", gc, 1); @(posedge clk); #1; drive(e3);
    wait_accept(gc); check("t3_grant2", gc, 0); @(posedge clk); #1; stop_req(0);
    wait_accept(gc); check("t3_grant3", gc, 1); @(posedge clk); #1; stop_req(1);
    drain();

    // Memory stalls for 5 cycles on a partial-strobe write from core1
    stall = 5;
    sb.push_back(mk(1, 1, 32'h302, 32'h5555_AAAA, 4'b0011, 0, 0, 7));
    drive(sb[0]);
    wait_accept(gc);
    @(posedge clk); #1;
    stop_req(1);
    drain();

    // Timeout while waiting for read data, then late rvalid in IDLE
    rd_en = 1'b0;
    sb.push_back(mk(0, 0, 32'h404, 0, 4'h0, 32'h0, 1, TMO + 1));
    drive(sb[0]);
    wait_accept(gc);
    @(posedge clk); #1;
    stop_req(0);
    drain();
    late_rvalid = 3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_late_ignored", {c0_rsp_valid, c1_rsp_valid}, 0);
    end
    rd_en = 1'b1;
    @(posedge clk); #1;

    // Timeout while the memory never accepts
    stall = 40;
    sb.push_back(mk(1, 1, 32'h408, 32'h7777_0000, 4'hF, 32'h0, 1, TMO + 1));
    drive(sb[0]);
    wait_accept(gc);
    @(posedge clk); #1;
    stop_req(1);
    drain();
    stall = 0;

    // core1 raises valid while core0's transaction is in flight
    sb.push_back(mk(0, 0, 32'h500, 0, 4'h0, 32'h0BAD_CAFE, 0, 3));
    drive(sb[0]);
    wait_accept(gc);
    @(posedge clk); #1;
    stop_req(0);
    sb.push_back(mk(1, 1, 32'h504, 32'h6666_6666, 4'hF, 0, 0, 2));
    drive(sb[1]);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      check("t6_ready_busy", c1_req_ready, 0);
      if (c0_rsp_valid) seen = 1'b1;
    end
    check("t6_resp_seen", seen, 1);
    @(negedge clk);
    check("t6_ready_next_idle", c1_req_ready, 1);
    @(posedge clk); #1;
    stop_req(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
